// File: rtl/timer16_pkg.sv
// Shared types and constants for the 16-bit countdown timer.
package timer16_pkg;

    localparam int unsigned TIMER_WIDTH = 16;
    localparam logic [TIMER_WIDTH-1:0] TIMER_ZERO = 16'h0000;

    // Encoding 2'd3 is unused and steers back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADED  = 2'd1,
        ST_RUNNING = 2'd2
    } timer_state_t;

endpackage

// File: rtl/countdown_timer16_dec16.sv
// Combinational 16-bit decrementer built as a ripple of half-subtractors.
module dec16 (
    output logic [15:0] dec_i0,
    output logic        borrow_out,
    input  logic [15:0] i0
);

    localparam int unsigned DW = 16;

    logic [DW:0] borrow;

    // Bit 0 subtracts one; every higher bit subtracts the borrow from below.
    always_comb begin
        borrow    = '0;
        dec_i0    = '0;
        borrow[0] = 1'b1;
        for (int i = 0; i < int'(DW); i++) begin
            dec_i0[i]     = i0[i] ^ borrow[i];
            borrow[i + 1] = ~i0[i] & borrow[i];
        end
        borrow_out = borrow[DW];
    end

endmodule

// File: rtl/countdown_timer16.sv
// Loadable 16-bit countdown timer with one-cycle expiry pulse and optional auto-reload.
module countdown_timer16
    import timer16_pkg::*;
#(
    parameter int unsigned WIDTH             = TIMER_WIDTH,
    parameter bit          ZERO_RELOAD_BLOCK = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             tick_en,
    input  logic             reload_en,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expired
);

    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             expired_q, expired_d;

    logic [WIDTH-1:0] count_dec;
    logic             count_zero;
    logic             count_one;
    logic             load_acc;
    logic             reload_ok;

    dec16 u_dec16 (
        .dec_i0     (count_dec),
        .borrow_out (count_zero),
        .i0         (count_q)
    );

    // dec16 only borrows out of the top bit when decrementing zero.
    assign count_one  = (count_q == WIDTH'(1));
    assign load_acc   = load_valid && (state_q != ST_RUNNING);
    assign reload_ok  = reload_en && (!ZERO_RELOAD_BLOCK || (reload_q != TIMER_ZERO));

    assign load_ready = (state_q != ST_RUNNING);
    assign busy       = (state_q == ST_RUNNING);
    assign count      = count_q;
    assign expired    = expired_q;

    // Next-state, counter and expiry logic.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        expired_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (load_acc) begin
                    count_d  = load_value;
                    reload_d = load_value;
                    state_d  = ST_LOADED;
                end
            end
            ST_LOADED: begin
                if (load_acc) begin
                    count_d  = load_value;
                    reload_d = load_value;
                end else if (start && !stop) begin
                    if (count_zero) begin
                        expired_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_RUNNING;
                    end
                end
            end
            ST_RUNNING: begin
                if (stop) begin
                    state_d = ST_LOADED;
                end else if (tick_en) begin
                    if (count_one) begin
                        expired_d = 1'b1;
                        if (reload_ok) begin
                            count_d = reload_q;
                        end else begin
                            count_d = TIMER_ZERO;
                            state_d = ST_IDLE;
                        end
                    end else if (!count_zero) begin
                        count_d = count_dec;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= TIMER_ZERO;
            reload_q  <= TIMER_ZERO;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            expired_q <= expired_d;
        end
    end

endmodule

// File: tb/tb_countdown_timer16.sv
// Self-checking bench for countdown_timer16 with a behavioural reference model.
module tb_countdown_timer16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_value = 16'h0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        tick_en = 1'b0;
    logic        reload_en = 1'b0;
    logic [15:0] count;
    logic        busy;
    logic        expired;

    logic [15:0] dec_in = 16'h0;
    logic [15:0] dec_out;
    logic        dec_borrow;

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;

    countdown_timer16 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .start      (start),
        .stop       (stop),
        .tick_en    (tick_en),
        .reload_en  (reload_en),
        .count      (count),
        .busy       (busy),
        .expired    (expired)
    );

    dec16 u_dec (
        .dec_i0     (dec_out),
        .borrow_out (dec_borrow),
        .i0         (dec_in)
    );

    always #5 clk = ~clk;

    // Reference model: "running" means counting, "armed" means holding a loaded value.
    bit          m_running = 1'b0;
    bit          m_armed = 1'b0;
    logic [15:0] m_count = 16'h0;
    logic [15:0] m_reload = 16'h0;
    bit          m_exp = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_running = 1'b0; m_armed = 1'b0;
            m_count = 16'h0; m_reload = 16'h0; m_exp = 1'b0;
        end else begin
            m_exp = 1'b0;
            if (!m_running && load_valid) begin
                m_count = load_value; m_reload = load_value; m_armed = 1'b1;
            end else if (m_armed && start && !stop) begin
                m_armed = 1'b0;
                if (m_count == 0) m_exp = 1'b1;
                else m_running = 1'b1;
            end else if (m_running && stop) begin
                m_running = 1'b0; m_armed = 1'b1;
            end else if (m_running && tick_en) begin
                if (m_count == 1) begin
                    m_exp = 1'b1;
                    if (reload_en && m_reload != 0) m_count = m_reload;
                    else begin m_count = 16'h0; m_running = 1'b0; end
                end else begin
                    m_count = 16'(m_count - 16'd1);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model count", 32'(count), 32'(m_count));
            chk("model busy", 32'(busy), 32'(m_running));
            chk("model load_ready", 32'(load_ready), 32'(!m_running));
            chk("model expired", 32'(expired), 32'(m_exp));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit lv, input logic [15:0] val, input bit st, input bit sp,
                         input bit tk, input bit rl);
        load_valid = lv; load_value = val; start = st; stop = sp; tick_en = tk; reload_en = rl;
    endtask

    // Checks DUT and model together against a hand-computed value.
    task automatic pin_count(input string name, input logic [15:0] exp);
        chk(name, 32'(count), 32'(exp));
        chk({name, " (model)"}, 32'(m_count), 32'(exp));
    endtask

    int npulse;

    initial begin
        // Reset and initial state.
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        chk_on = 1'b1;
        chk("reset count", 32'(count), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset load_ready", 32'(load_ready), 32'h1);
        chk("reset expired", 32'(expired), 32'h0);

        // Load 3, run to expiry without reload.
        drive(1, 16'd3, 0, 0, 0, 0); step();
        pin_count("load3 count", 16'd3);
        chk("load3 busy", 32'(busy), 32'h0);
        drive(0, 16'd0, 1, 0, 1, 0); step();
        chk("start busy", 32'(busy), 32'h1);
        pin_count("start count", 16'd3);
        step(); pin_count("tick1", 16'd2);
        step(); pin_count("tick2", 16'd1);
        chk("tick2 expired", 32'(expired), 32'h0);
        step(); pin_count("tick3", 16'd0);
        chk("tick3 expired", 32'(expired), 32'h1);
        chk("tick3 busy", 32'(busy), 32'h0);
        step();
        chk("post expiry pulse", 32'(expired), 32'h0);
        chk("start held idle busy", 32'(busy), 32'h0);

        // Load 2 with auto-reload, seven ticks.
        drive(1, 16'd2, 0, 0, 0, 1); step();
        drive(0, 16'd0, 1, 0, 1, 1); step();
        npulse = 0;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (expired) npulse++;
            pin_count("reload count", (k % 2 == 1) ? 16'd1 : 16'd2);
            chk("reload busy", 32'(busy), 32'h1);
        end
        chk("reload pulses", 32'(npulse), 32'd3);
        drive(0, 16'd0, 0, 1, 0, 0); step();
        chk("pause busy", 32'(busy), 32'h0);

        // Pause at 2 (stop beats tick), then resume to one expiry.
        drive(1, 16'd4, 0, 0, 0, 0); step();
        drive(0, 16'd0, 1, 0, 1, 0); step();
        step(); step();
        pin_count("pre-stop count", 16'd2);
        drive(0, 16'd0, 0, 1, 1, 0); step();
        pin_count("stop hold", 16'd2);
        chk("stop busy", 32'(busy), 32'h0);
        drive(0, 16'd0, 1, 0, 1, 0); step();
        chk("resume busy", 32'(busy), 32'h1);
        npulse = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (expired) npulse++;
        end
        pin_count("resume end", 16'd0);
        chk("resume pulses", 32'(npulse), 32'd1);

        // Zero load with reload_en: single pulse, no reload loop.
        drive(1, 16'd0, 0, 0, 0, 1); step();
        drive(0, 16'd0, 1, 0, 1, 1); step();
        chk("zero expired", 32'(expired), 32'h1);
        chk("zero busy", 32'(busy), 32'h0);
        step();
        chk("zero no repeat", 32'(expired), 32'h0);
        pin_count("zero count", 16'd0);

        // Load wins over start in LOADED; load ignored while running.
        drive(1, 16'd5, 0, 0, 0, 0); step();
        drive(1, 16'h1234, 1, 0, 0, 0); step();
        pin_count("load beats start", 16'h1234);
        chk("load beats start busy", 32'(busy), 32'h0);
        drive(0, 16'd0, 1, 0, 0, 0); step();
        chk("running load_ready", 32'(load_ready), 32'h0);
        drive(1, 16'hBEEF, 1, 0, 1, 0); step();
        pin_count("ignored load", 16'h1233);

        // Reset mid-run at count 5, observed before the next edge.
        drive(0, 16'd0, 0, 1, 0, 0); step();
        drive(1, 16'd7, 0, 0, 0, 0); step();
        drive(0, 16'd0, 1, 0, 1, 0); step();
        step(); step();
        pin_count("pre-reset count", 16'd5);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset count", 32'(count), 32'h0);
        chk("async reset busy", 32'(busy), 32'h0);
        chk("async reset ready", 32'(load_ready), 32'h1);
        chk("async reset expired", 32'(expired), 32'h0);
        step();
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [15:0] v;
            v = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 4));
            drive($urandom_range(0, 99) < 15, v, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            step();
        end
        rst_n = 1'b1;
        chk_on = 1'b0;

        // Standalone decrementer.
        dec_in = 16'h0000; #1;
        chk("dec16 0000", 32'(dec_out), 32'hFFFF);
        chk("dec16 0000 borrow", 32'(dec_borrow), 32'h1);
        dec_in = 16'h8000; #1;
        chk("dec16 8000", 32'(dec_out), 32'h7FFF);
        chk("dec16 8000 borrow", 32'(dec_borrow), 32'h0);
        for (int i = 0; i < 50; i++) begin
            dec_in = 16'($urandom); #1;
            chk("dec16 random", 32'(dec_out), 32'(16'(dec_in - 16'd1)));
            chk("dec16 random borrow", 32'(dec_borrow), 32'(dec_in == 16'h0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/countdown_timer16.md
Name: countdown_timer16

Overview:
- 16-bit loadable countdown timer: the decrementing counterpart to the team's 16-bit incrementer datapath.
- Accepts a start value over a valid/ready load handshake and decrements once per enabled tick.
- Flags expiry with a one-cycle pulse and can optionally auto-reload the last loaded value.
- Used as the watchdog/delay source next to the program-counter logic in the CPU datapath.

Parameters:
- WIDTH, 16, counter width; fixed at 16 because the dec16 sub-module is 16 bits wide.
- ZERO_RELOAD_BLOCK, 1, when 1 a zero start value never auto-reloads (prevents a zero-period loop).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- load_valid  input  1  load request.
- load_ready  output  1  block can accept a load.
- load_value  input  16  start value.
- start  input  1  begin/resume counting (level-sampled).
- stop  input  1  pause counting.
- tick_en  input  1  decrement enable for this cycle.
- reload_en  input  1  auto-reload on expiry.
- count  output  16  current counter value (registered).
- busy  output  1  high while in RUNNING.
- expired  output  1  one-cycle expiry pulse (registered).

Behaviour:
- Reset: while rst_n=0, asynchronously force state=IDLE, count=0, reload_reg=0, expired=0. This gives busy=0 and load_ready=1. Reset mid-run aborts immediately; no expiry pulse is produced.
- States: IDLE=0, LOADED=1, RUNNING=2 (2-bit encoding; value 3 is illegal and recovers to IDLE on the next edge).
- load_ready = (state != RUNNING). It is combinational from state only.
- Load accept (load_valid & load_ready):
  - count <= load_value; reload_reg <= load_value; next state is LOADED.
  - Accepted in IDLE or LOADED. In LOADED a second load overwrites the first.
  - When load and start are both high in LOADED, the load wins and start is ignored that cycle.
- LOADED:
  - start & ~stop & count!=0 -> RUNNING.
  - start & ~stop & count==0 -> expired<=1, state<=IDLE. No reload, regardless of reload_en.
  - stop, or start and stop together -> remain in LOADED.
- RUNNING:
  - stop=1 -> LOADED (pause); count holds. stop has priority over tick_en in the same cycle.
  - tick_en=0 -> count holds.
  - tick_en=1 and count>1 -> count <= dec16(count), i.e. count-1.
  - tick_en=1 and count==1:
    - expired<=1 on the same edge.
    - If reload_en=1 and reload_reg!=0 (given ZERO_RELOAD_BLOCK=1): count<=reload_reg, stay RUNNING.
    - Otherwise: count<=0, state<=IDLE.
  - count is never decremented at 0, so no wrap-around to 0xFFFF can occur.
- expired is high for exactly one cycle per expiry and is cleared on the following edge.
- Latency:
  - N ticks after entering RUNNING with count=N, expired is high in the cycle after the Nth tick edge.
  - Consecutive auto-reload periods are exactly reload_reg ticks apart.
- busy = (state==RUNNING).
- start is level-sensitive. Holding it high after expiry does nothing in IDLE; the block needs a new load first.

Decomposition:
- Shared package timer16_pkg:
  - typedef timer_state_t covering IDLE, LOADED, RUNNING (2-bit).
  - Constants TIMER_WIDTH=16 and TIMER_ZERO=16'h0000.
- Sub-module dec16:
  - Combinational 16-bit decrement, mirror of the incrementer.
  - Ripple chain of half-subtractors: bit 0 subtracts 1'b1, each later bit subtracts the borrow from the bit below.
  - Ports: dec_i0[15:0] out, borrow_out out, i0[15:0] in.
- The top level contains only the FSM, count/reload_reg registers and zero/one detection.

Test Plan:
- Reset during RUNNING at count=0x0005 -> count=0, busy=0, expired stays 0, load_ready=1 with no clock edge needed.
- Load 3, start, tick_en=1 every cycle, reload_en=0 -> count sequence 3,2,1,0; expired high for one cycle on the edge where count becomes 0; then state=IDLE and busy=0.
- Load 2, reload_en=1, continuous ticks for 7 cycles -> expired pulses exactly every 2 ticks; count cycles 2,1,2,1,...; busy stays 1.
- Load 0x0004, start, assert stop together with tick_en at count=2 -> count holds 2 and state=LOADED. Deassert stop, start again -> resumes 2,1,0 with a single expiry.
- Load 0 then start with reload_en=1 -> expired pulses once, state=IDLE, count=0, no reload loop.
- In LOADED, load_valid with 0x1234 and start in the same cycle -> count=0x1234, state remains LOADED. During RUNNING, load_ready=0 and a load_valid of 0xBEEF is ignored. Also run dec16 standalone with 0x0000 -> 0xFFFF with borrow_out=1, and 0x8000 -> 0x7FFF.
